// File: rtl/wave_capture_trigger.sv
// Trigger and capture front end for the oscilloscope waveform RAM. It waits for a
// positive-going zero crossing, writes 256 samples to the inactive half, then swaps halves in vsync.
module wave_capture_trigger #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        new_sample_ready,
    input  logic [15:0] new_sample_in,
    input  logic        wave_display_idle,
    output logic [8:0]  write_address,
    output logic        write_enable,
    output logic [7:0]  write_sample,
    output logic        read_index
);

    localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_ARMED, S_ACTIVE, S_WAIT} state_t;

    state_t          state_q, state_d;
    logic [7:0]      count_q, count_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            prev_neg_q, prev_neg_d;
    logic            idle_d_q;
    logic            read_index_q, read_index_d;
    logic            write_enable_q, write_enable_d;
    logic [8:0]      write_address_q, write_address_d;
    logic [7:0]      write_sample_q, write_sample_d;

    logic            idle_rise;
    logic            do_write;
    logic [7:0]      wr_count;

    assign idle_rise = wave_display_idle & ~idle_d_q;

    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        to_cnt_d        = to_cnt_q;
        prev_neg_d      = prev_neg_q;
        read_index_d    = read_index_q;
        write_enable_d  = 1'b0;
        write_address_d = write_address_q;
        write_sample_d  = write_sample_q;
        do_write        = 1'b0;
        wr_count        = count_q;

        // The sign history is tracked in every state so that a sample arriving
        // during the swap can still arm the next crossing.
        if (new_sample_ready) prev_neg_d = new_sample_in[15];

        case (state_q)
            S_ARMED: begin
                if (new_sample_ready) begin
                    if ((prev_neg_q && !new_sample_in[15]) || (to_cnt_q == TO_LAST)) begin
                        do_write = 1'b1;
                        wr_count = 8'd0;
                        count_d  = 8'd1;
                        state_d  = S_ACTIVE;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
            end
            S_ACTIVE: begin
                if (new_sample_ready) begin
                    do_write = 1'b1;
                    count_d  = count_q + 8'd1;
                    if (count_q == 8'hFF) state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (idle_rise) begin
                    read_index_d = ~read_index_q;
                    to_cnt_d     = '0;
                    state_d      = S_ARMED;
                end
            end
            default: state_d = S_ARMED;
        endcase

        if (do_write) begin
            write_enable_d  = 1'b1;
            write_address_d = {~read_index_q, wr_count};
            write_sample_d  = {~new_sample_in[15], new_sample_in[14:8]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_ARMED;
            count_q         <= '0;
            to_cnt_q        <= '0;
            prev_neg_q      <= 1'b0;
            idle_d_q        <= 1'b0;
            read_index_q    <= 1'b0;
            write_enable_q  <= 1'b0;
            write_address_q <= '0;
            write_sample_q  <= '0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            to_cnt_q        <= to_cnt_d;
            prev_neg_q      <= prev_neg_d;
            idle_d_q        <= wave_display_idle;
            read_index_q    <= read_index_d;
            write_enable_q  <= write_enable_d;
            write_address_q <= write_address_d;
            write_sample_q  <= write_sample_d;
        end
    end

    assign write_address = write_address_q;
    assign write_enable  = write_enable_q;
    assign write_sample  = write_sample_q;
    assign read_index    = read_index_q;

endmodule

// File: tb/tb_wave_capture_trigger.sv
// Directed bench for wave_capture_trigger. Each scenario has its own task, and the
// expected RAM writes and buffer index are written out by hand.
module tb_wave_capture_trigger;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        new_sample_ready = 1'b0;
    logic [15:0] new_sample_in = '0;
    logic        wave_display_idle = 1'b0;
    logic [8:0]  write_address;
    logic        write_enable;
    logic [7:0]  write_sample;
    logic        read_index;

    int n_checks = 0;
    int n_fail   = 0;

    wave_capture_trigger #(.TIMEOUT(1024)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .new_sample_ready  (new_sample_ready),
        .new_sample_in     (new_sample_in),
        .wave_display_idle (wave_display_idle),
        .write_address     (write_address),
        .write_enable      (write_enable),
        .write_sample      (write_sample),
        .read_index        (read_index)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        reset_n = 1'b0;
        new_sample_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Drive one strobe at the falling edge and return just after the capturing rising edge.
    task automatic strobe(input logic [15:0] v);
        @(negedge clk);
        new_sample_ready = 1'b1;
        new_sample_in    = v;
        @(posedge clk);
        #1;
        new_sample_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if ({write_enable, write_address, write_sample, read_index} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got we=%0b addr=%h data=%h ri=%0b, want all 0",
                     write_enable, write_address, write_sample, read_index);
        end
    endtask

    task automatic test_trigger();
        do_reset();
        strobe(16'hFFFB);
        n_checks++;
        if (write_enable !== 1'b0) begin n_fail++; $display("FAIL trig_no_write_m5: we=%0b want 0", write_enable); end
        strobe(16'hFFFF);
        n_checks++;
        if (write_enable !== 1'b0) begin n_fail++; $display("FAIL trig_no_write_m1: we=%0b want 0", write_enable); end
        strobe(16'h0003);
        n_checks++;
        if ({write_enable, write_address, write_sample} !== {1'b1, 9'h100, 8'h80}) begin
            n_fail++;
            $display("FAIL trig_first_write: we=%0b addr=%h data=%h want 1/100/80", write_enable, write_address, write_sample);
        end
        strobe(16'h0007);
        n_checks++;
        if ({write_enable, write_address, write_sample} !== {1'b1, 9'h101, 8'h80}) begin
            n_fail++;
            $display("FAIL trig_second_write: we=%0b addr=%h data=%h want 1/101/80", write_enable, write_address, write_sample);
        end
        @(posedge clk); #1;
        n_checks++;
        if (write_enable !== 1'b0) begin n_fail++; $display("FAIL trig_we_one_cycle: we=%0b want 0", write_enable); end
    endtask

    task automatic test_capture();
        int bad;
        do_reset();
        strobe(16'hFFFF);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            strobe(16'(i * 128));
            n_checks++;
            if ({write_enable, write_address, write_sample} !== {1'b1, 9'(9'h100 + i), 8'(8'h80 | (i >> 1))}) begin
                n_fail++;
                if (bad < 4)
                    $display("FAIL cap_write[%0d]: we=%0b addr=%h data=%h want 1/%h/%h", i,
                             write_enable, write_address, write_sample, 9'(9'h100 + i), 8'(8'h80 | (i >> 1)));
                bad++;
            end
        end
        strobe(16'h1234);
        n_checks++;
        if (write_enable !== 1'b0) begin n_fail++; $display("FAIL cap_wait_no_write: we=%0b want 0", write_enable); end
        n_checks++;
        if (read_index !== 1'b0) begin n_fail++; $display("FAIL cap_ri_before_swap: ri=%0b want 0", read_index); end
        // Strobe lands on the same edge as the vsync rise: swap, no write, sign still recorded.
        @(negedge clk);
        wave_display_idle = 1'b1;
        new_sample_ready  = 1'b1;
        new_sample_in     = 16'hFFFC;
        @(posedge clk); #1;
        new_sample_ready  = 1'b0;
        n_checks++;
        if ({read_index, write_enable} !== 2'b10) begin
            n_fail++;
            $display("FAIL cap_swap_simul: ri=%0b we=%0b want ri=1 we=0", read_index, write_enable);
        end
        @(negedge clk);
        wave_display_idle = 1'b0;
        strobe(16'h0004);
        n_checks++;
        if ({write_enable, write_address, write_sample} !== {1'b1, 9'h000, 8'h80}) begin
            n_fail++;
            $display("FAIL cap2_first_write: we=%0b addr=%h data=%h want 1/000/80", write_enable, write_address, write_sample);
        end
        strobe(16'h8000);
        n_checks++;
        if ({write_enable, write_address, write_sample} !== {1'b1, 9'h001, 8'h00}) begin
            n_fail++;
            $display("FAIL cap2_min_sample: we=%0b addr=%h data=%h want 1/001/00", write_enable, write_address, write_sample);
        end
    endtask

    task automatic test_idle_held();
        int nwr;
        do_reset();
        @(negedge clk);
        wave_display_idle = 1'b1;
        strobe(16'hFFFF);
        nwr = 0;
        for (int i = 0; i < 256; i++) begin
            strobe(16'h0100);
            if (write_enable === 1'b1) nwr++;
        end
        n_checks++;
        if (nwr !== 256) begin n_fail++; $display("FAIL held_write_count: got %0d want 256", nwr); end
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (read_index !== 1'b0) begin n_fail++; $display("FAIL held_no_swap: ri=%0b want 0", read_index); end
        @(negedge clk);
        wave_display_idle = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (read_index !== 1'b0) begin n_fail++; $display("FAIL held_no_swap_low: ri=%0b want 0", read_index); end
        @(negedge clk);
        wave_display_idle = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (read_index !== 1'b1) begin n_fail++; $display("FAIL held_swap_on_rise: ri=%0b want 1", read_index); end
        @(negedge clk);
        wave_display_idle = 1'b0;
    endtask

    task automatic test_timeout();
        int early;
        do_reset();
        early = 0;
        for (int i = 1; i < 1024; i++) begin
            strobe(16'd100);
            if (write_enable !== 1'b0) early++;
        end
        n_checks++;
        if (early !== 0) begin n_fail++; $display("FAIL to_early_write: got %0d writes want 0", early); end
        strobe(16'd100);
        n_checks++;
        if ({write_enable, write_address, write_sample} !== {1'b1, 9'h100, 8'h80}) begin
            n_fail++;
            $display("FAIL to_forced_trigger: we=%0b addr=%h data=%h want 1/100/80", write_enable, write_address, write_sample);
        end
        strobe(16'd100);
        n_checks++;
        if ({write_enable, write_address} !== {1'b1, 9'h101}) begin
            n_fail++;
            $display("FAIL to_after_forced: we=%0b addr=%h want 1/101", write_enable, write_address);
        end
    endtask

    task automatic test_extremes_reset();
        do_reset();
        strobe(16'h8000);
        n_checks++;
        if (write_enable !== 1'b0) begin n_fail++; $display("FAIL ext_min_no_write: we=%0b want 0", write_enable); end
        strobe(16'h7FFF);
        n_checks++;
        if ({write_enable, write_address, write_sample} !== {1'b1, 9'h100, 8'hFF}) begin
            n_fail++;
            $display("FAIL ext_max_write: we=%0b addr=%h data=%h want 1/100/FF", write_enable, write_address, write_sample);
        end
        strobe(16'h0100);
        n_checks++;
        if ({write_enable, write_address, write_sample} !== {1'b1, 9'h101, 8'h81}) begin
            n_fail++;
            $display("FAIL ext_trunc_write: we=%0b addr=%h data=%h want 1/101/81", write_enable, write_address, write_sample);
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({write_enable, write_address, write_sample, read_index} !== 19'd0) begin
            n_fail++;
            $display("FAIL ext_async_reset: we=%0b addr=%h data=%h ri=%0b want all 0",
                     write_enable, write_address, write_sample, read_index);
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        strobe(16'h0001);
        n_checks++;
        if (write_enable !== 1'b0) begin n_fail++; $display("FAIL ext_post_reset_no_trig: we=%0b want 0", write_enable); end
    endtask

    initial begin
        test_reset();
        test_trigger();
        test_capture();
        test_idle_held();
        test_timeout();
        test_extremes_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wave_capture_trigger.md
# wave_capture_trigger

Front end of the oscilloscope path: takes the 16-bit signed audio sample stream, waits for a positive-going zero crossing, and writes 256 consecutive samples as 8-bit offset-binary into the inactive half of the 512-entry double-buffered waveform RAM. Once a capture is complete, it swaps buffers during the next vertical blanking, signalled by `wave_display_idle` from `wave_display`. Its `read_index` output drives the display's buffer select, so the display only ever reads a completed buffer.

## Interface
Parameters:
- `TIMEOUT`, 1024 — samples in ARMED with no trigger before a forced (auto) trigger; must be ≥ 2.

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `new_sample_ready`  in  1  one-cycle strobe; `new_sample_in` is valid this cycle
- `new_sample_in`  in  16  two's-complement audio sample
- `wave_display_idle`  in  1  high during vsync (display not reading RAM)
- `write_address`  out  9  RAM write address `{~read_index, count[7:0]}`
- `write_enable`  out  1  one-cycle RAM write strobe
- `write_sample`  out  8  `{~new_sample_in[15], new_sample_in[14:8]}` (offset binary)
- `read_index`  out  1  buffer the display reads; capture writes the other one

## Operation
- Registers: `state` (ARMED / ACTIVE / WAIT), `count[7:0]`, `prev_neg`, `idle_d`, `read_index`, `to_cnt`, and the output registers.
- `prev_neg` holds `new_sample_in[15]` of the last strobed sample. It updates on every strobe in every state.
- `idle_d` is `wave_display_idle` delayed one cycle. `idle_rise = wave_display_idle & ~idle_d`.
- ARMED:
  - On a strobe with `prev_neg==1` and `new_sample_in[15]==0`: trigger. Write this sample at count 0, set `count=1`, go to ACTIVE.
  - On a strobe with `to_cnt==TIMEOUT-1`: forced trigger, with the same write and transition.
  - On any other strobe: `to_cnt++`.
  - `to_cnt` clears on every entry to ARMED.
- ACTIVE:
  - Each strobe writes the sample at `count`, then `count++`.
  - The strobe that writes `count==255` moves the block to WAIT. `count` wraps to 0.
  - No trigger check in this state.
- WAIT:
  - Strobes are ignored for writing; they still update `prev_neg`.
  - On `idle_rise`: toggle `read_index`, go to ARMED.
  - `idle_rise` is only acted on in WAIT. A vsync already in progress when WAIT is entered is not used; the block waits for the next rising edge.
- Simultaneous strobe and `idle_rise` in WAIT: swap happens and the strobe is not written. Its sign does update `prev_neg`, so the next sample can trigger.
- Width rules:
  - `write_sample` truncates: the low byte is dropped, no rounding.
  - `write_address[8]` is `~read_index` as sampled at the write cycle. It never changes during a capture, because `read_index` only toggles in WAIT.

## Timing
- Registered outputs: `write_enable`, `write_address`, `write_sample` are valid the cycle after the qualifying strobe (latency 1). `write_enable` is high for exactly one cycle per written sample.
- Exactly 256 writes per capture, at addresses `{~read_index, 8'd0}` … `{~read_index, 8'd255}` in order.
- `read_index` changes one cycle after the `wave_display_idle` rising edge, i.e. inside vsync.
- Reset (`reset_n` low, asynchronous):
  - state=ARMED, `count=0`, `to_cnt=0`, `prev_neg=0`, `idle_d=0`
  - `read_index=0`, `write_enable=0`, `write_address=0`, `write_sample=0`
- Reset mid-capture abandons the partial buffer. No swap occurs. The first post-reset sample cannot trigger, because `prev_neg=0`.
- Back-to-back strobes on consecutive cycles are supported; the minimum strobe spacing is 1 cycle.

## Test plan
- Reset, then strobes −5, −1, +3, +7 → trigger on +3. First write at addr 0x100, data 0x80. +7 writes at 0x101, data 0x80. No write for −5 or −1.
- Complete capture from a triggered ramp (256 strobes) → 256 writes at 0x100–0x1FF, then WAIT. Further strobes produce no writes. A `wave_display_idle` pulse gives `read_index=1` one cycle after its rise. The next capture writes 0x000–0x0FF.
- `wave_display_idle` already high when WAIT is entered → no swap until it falls and rises again.
- Constant +100 input with `TIMEOUT`=1024 → forced trigger on the 1024th strobe after entering ARMED. Writes data 0x80 (100>>8 = 0, sign bit clear).
- Strobe −32768 then 0x7FFF → trigger. Data 0x00 is not written (it precedes the trigger); 0x7FFF writes 0xFF. Then assert `reset_n` low mid-capture → outputs zero immediately and `read_index` stays unchanged at 0.
